// File: rtl/flex_stp_pkg.sv
// Shared types and constants for the flexible serial-to-parallel word receiver.
package flex_stp_pkg;

  typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_t;

  localparam int MAX_BITS = 32;

  // Idle-line fill pattern: the low 'width' bits set.
  function automatic logic [MAX_BITS-1:0] fill_ones(input int width);
    logic [MAX_BITS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/stp_bit_counter.sv
// Wrapping bit counter with enable, synchronous clear and a terminal-count strobe.
module stp_bit_counter #(
  parameter  int NUM_BITS = 8,
  localparam int CNT_W    = $clog2(NUM_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BITS - 1);

  assign terminal = enable && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/flex_stp_word.sv
// Serial-to-parallel word receiver: shift register, bit counter, one-entry
// valid/ready holding register and sticky overflow flag.
module flex_stp_word
  import flex_stp_pkg::*;
#(
  parameter  int NUM_BITS  = 8,
  parameter  int SHIFT_MSB = 1,
  localparam int CNT_W     = $clog2(NUM_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  input  logic                clear,
  output logic [NUM_BITS-1:0] parallel_out,
  output logic [CNT_W-1:0]    bit_count,
  output logic [NUM_BITS-1:0] word_data,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                overflow,
  input  logic                overflow_clr
);

  localparam logic [NUM_BITS-1:0] FILL = NUM_BITS'(fill_ones(NUM_BITS));

  logic [NUM_BITS-1:0] sreg;
  logic [NUM_BITS-1:0] shifted;
  logic                step;
  logic                done;
  hold_state_t         state;

  // clear wins over shift_enable, so a bit arriving with clear never counts or completes a word.
  assign step = shift_enable & ~clear;

  generate
    if (SHIFT_MSB != 0) begin : g_msb
      assign shifted = {sreg[NUM_BITS-2:0], serial_in};
    end else begin : g_lsb
      assign shifted = {serial_in, sreg[NUM_BITS-1:1]};
    end
  endgenerate

  stp_bit_counter #(.NUM_BITS(NUM_BITS)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .enable   (step),
    .clear    (clear),
    .count    (bit_count),
    .terminal (done)
  );

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sreg <= FILL;
    end else if (step) begin
      sreg <= shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD_EMPTY;
      word_data <= FILL;
      overflow  <= 1'b0;
    end else begin
      // Cleared first so a drop in the same cycle overrides it.
      if (overflow_clr) overflow <= 1'b0;
      case (state)
        HOLD_EMPTY: begin
          if (done) begin
            word_data <= shifted;
            state     <= HOLD_FULL;
          end
        end
        HOLD_FULL: begin
          if (done) begin
            if (word_ready) word_data <= shifted;
            else            overflow  <= 1'b1;
          end else if (word_ready) begin
            state <= HOLD_EMPTY;
          end
        end
        default: state <= HOLD_EMPTY;
      endcase
    end
  end

  assign parallel_out = sreg;
  assign word_valid   = (state == HOLD_FULL);

endmodule

// File: tb/tb_flex_stp_word.sv
// Self-checking bench for flex_stp_word: MSB-first and LSB-first instances share
// stimulus; a scoreboard checks every word the holding register loads.
module tb_flex_stp_word;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       shift_enable = 1'b0;
  logic       serial_in = 1'b0;
  logic       clear = 1'b0;
  logic       word_ready = 1'b0;
  logic       overflow_clr = 1'b0;

  logic [7:0] parallel_out, word_data, po_l, wd_l;
  logic [2:0] bit_count, bc_l;
  logic       word_valid, overflow, wv_l, of_l;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  logic [7:0] ql[$];
  logic [7:0] exp_m, exp_l, prev_d, prev_dl;
  logic       prev_v = 1'b0;
  logic       prev_vl = 1'b0;

  always #5 clk = ~clk;

  flex_stp_word #(.NUM_BITS(8), .SHIFT_MSB(1)) dut (
    .clk(clk), .rst(rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .parallel_out(parallel_out), .bit_count(bit_count),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  flex_stp_word #(.NUM_BITS(8), .SHIFT_MSB(0)) dut_l (
    .clk(clk), .rst(rst), .shift_enable(shift_enable), .serial_in(serial_in),
    .clear(clear), .parallel_out(po_l), .bit_count(bc_l),
    .word_data(wd_l), .word_valid(wv_l), .word_ready(word_ready),
    .overflow(of_l), .overflow_clr(overflow_clr)
  );

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Scoreboard: a word is "produced" when valid rises or the held data changes while valid.
  always @(negedge clk) begin
    if (word_valid && (!prev_v || word_data !== prev_d)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_msb unexpected word got=%h required=none", word_data);
      end else begin
        exp_m = q.pop_front();
        if (word_data !== exp_m) begin
          bad++;
          $display("FAIL sb_msb word got=%h required=%h", word_data, exp_m);
        end
      end
    end
    if (wv_l && (!prev_vl || wd_l !== prev_dl)) begin
      total++;
      if (ql.size() == 0) begin
        bad++;
        $display("FAIL sb_lsb unexpected word got=%h required=none", wd_l);
      end else begin
        exp_l = ql.pop_front();
        if (wd_l !== exp_l) begin
          bad++;
          $display("FAIL sb_lsb word got=%h required=%h", wd_l, exp_l);
        end
      end
    end
    prev_v  = word_valid;
    prev_d  = word_data;
    prev_vl = wv_l;
    prev_dl = wd_l;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] v);
    q.push_back(v);
    ql.push_back(rev8(v));
  endtask

  task automatic shift_bit(input logic b);
    shift_enable = 1'b1;
    serial_in    = b;
    tick();
  endtask

  task automatic send_bits(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic idle();
    shift_enable = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; shift_enable = 1'b0; clear = 1'b0; overflow_clr = 1'b0; word_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (parallel_out !== 8'hFF) begin bad++; $display("FAIL reset_po got=%h required=ff", parallel_out); end
    total++; if (bit_count !== 3'd0) begin bad++; $display("FAIL reset_bc got=%0d required=0", bit_count); end
    total++; if (word_data !== 8'hFF) begin bad++; $display("FAIL reset_wd got=%h required=ff", word_data); end
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_wv got=%b required=0", word_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_of got=%b required=0", overflow); end
  endtask

  task automatic test_msb_first();
    do_reset();
    word_ready = 1'b1;
    push_word(8'hA5);
    send_bits(8'hA5);
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL msb_valid got=%b required=1", word_valid); end
    total++; if (bit_count !== 3'd0) begin bad++; $display("FAIL msb_bc got=%0d required=0", bit_count); end
    total++; if (parallel_out !== 8'hA5) begin bad++; $display("FAIL msb_po got=%h required=a5", parallel_out); end
    idle();
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL msb_one_cycle got=%b required=0", word_valid); end
  endtask

  task automatic test_lsb_first();
    do_reset();
    word_ready = 1'b1;
    push_word(8'h80);
    send_bits(8'h80);
    total++; if (parallel_out !== 8'h80) begin bad++; $display("FAIL lsb_po_msbdut got=%h required=80", parallel_out); end
    total++; if (po_l !== 8'h01) begin bad++; $display("FAIL lsb_po got=%h required=01", po_l); end
    total++; if (wv_l !== 1'b1) begin bad++; $display("FAIL lsb_valid got=%b required=1", wv_l); end
    idle();
  endtask

  task automatic test_backpressure();
    logic [7:0] v;
    do_reset();
    word_ready = 1'b0;
    push_word(8'h3C);
    send_bits(8'h3C);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_of_first got=%b required=0", overflow); end
    send_bits(8'hC3);
    total++; if (word_data !== 8'h3C) begin bad++; $display("FAIL bp_wd_kept got=%h required=3c", word_data); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_of_set got=%b required=1", overflow); end
    shift_enable = 1'b0;
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_of_clr got=%b required=0", overflow); end
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_kept got=%b required=1", word_valid); end
    // Drop and overflow_clr on the same edge: set must win.
    v = 8'h5A;
    for (int i = 7; i >= 1; i--) shift_bit(v[i]);
    overflow_clr = 1'b1;
    shift_bit(v[0]);
    overflow_clr = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_set_wins got=%b required=1", overflow); end
    word_ready = 1'b1;
    idle();
    word_ready = 1'b0;
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b required=0", word_valid); end
    total++; if (word_data !== 8'h3C) begin bad++; $display("FAIL bp_wd_after_drain got=%h required=3c", word_data); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] v;
    do_reset();
    word_ready = 1'b0;
    push_word(8'h11);
    send_bits(8'h11);
    push_word(8'h22);
    v = 8'h22;
    for (int i = 7; i >= 1; i--) shift_bit(v[i]);
    word_ready = 1'b1;
    shift_bit(v[0]);
    word_ready = 1'b0;
    total++; if (word_data !== 8'h22) begin bad++; $display("FAIL sim_wd got=%h required=22", word_data); end
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL sim_valid got=%b required=1", word_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL sim_of got=%b required=0", overflow); end
    word_ready = 1'b1;
    idle();
    word_ready = 1'b0;
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL sim_drain got=%b required=0", word_valid); end
  endtask

  task automatic test_clear();
    do_reset();
    word_ready = 1'b0;
    push_word(8'hA5);
    send_bits(8'hA5);
    shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
    total++; if (bit_count !== 3'd3) begin bad++; $display("FAIL clr_pre_bc got=%0d required=3", bit_count); end
    clear = 1'b1;
    shift_bit(1'b1);
    clear = 1'b0;
    shift_enable = 1'b0;
    total++; if (parallel_out !== 8'hFF) begin bad++; $display("FAIL clr_po got=%h required=ff", parallel_out); end
    total++; if (bit_count !== 3'd0) begin bad++; $display("FAIL clr_bc got=%0d required=0", bit_count); end
    total++; if (word_data !== 8'hA5) begin bad++; $display("FAIL clr_wd_kept got=%h required=a5", word_data); end
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL clr_valid_kept got=%b required=1", word_valid); end
    word_ready = 1'b1;
    idle();
    word_ready = 1'b0;
    push_word(8'h5A);
    send_bits(8'h5A);
    shift_enable = 1'b0;
    total++; if (parallel_out !== 8'h5A) begin bad++; $display("FAIL clr_next_po got=%h required=5a", parallel_out); end
    total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL clr_next_valid got=%b required=1", word_valid); end
    word_ready = 1'b1;
    idle();
    word_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [3];
    vals = '{8'h12, 8'h34, 8'hE7};
    do_reset();
    word_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_word(vals[k]);
      send_bits(vals[k]);
      total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_%0d got=%b required=1", k, word_valid); end
      total++; if (bit_count !== 3'd0) begin bad++; $display("FAIL b2b_bc_%0d got=%0d required=0", k, bit_count); end
    end
    idle();
    word_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    word_ready = 1'b0;
    push_word(8'h3C);
    send_bits(8'h3C);
    send_bits(8'hC3);
    for (int i = 0; i < 5; i++) shift_bit(i[0]);
    shift_enable = 1'b0;
    total++; if (bit_count !== 3'd5) begin bad++; $display("FAIL rmid_pre_bc got=%0d required=5", bit_count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL rmid_pre_of got=%b required=1", overflow); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (parallel_out !== 8'hFF) begin bad++; $display("FAIL rmid_po got=%h required=ff", parallel_out); end
    total++; if (bit_count !== 3'd0) begin bad++; $display("FAIL rmid_bc got=%0d required=0", bit_count); end
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL rmid_wv got=%b required=0", word_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rmid_of got=%b required=0", overflow); end
    total++; if (word_data !== 8'hFF) begin bad++; $display("FAIL rmid_wd got=%h required=ff", word_data); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_simultaneous();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    idle();
    idle();
    total++; if (q.size() != 0) begin bad++; $display("FAIL sb_msb_leftover got=%0d required=0", q.size()); end
    total++; if (ql.size() != 0) begin bad++; $display("FAIL sb_lsb_leftover got=%0d required=0", ql.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
